// File: rtl/fmul_sched.sv
// Purpose: two-port round-robin scheduler for one multi-cycle FP32 multiplier; operands/products pass through untouched.
// Latency: accept in cycle T -> o_resp_valid first high in cycle T+1+LOAD_CYCLES+LATENCY, one operation in flight.
// Backpressure: a result is held in DONE until i_resp_ready; requests are only accepted in IDLE (o_req_ready low otherwise).
module fmul_sched #(
    parameter int WIDTH       = 32,
    parameter int LOAD_CYCLES = 2,
    parameter int LATENCY     = 35
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [WIDTH-1:0] i_req_a0,
    input  logic [WIDTH-1:0] i_req_b0,
    input  logic [WIDTH-1:0] i_req_a1,
    input  logic [WIDTH-1:0] i_req_b1,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic             o_resp_id,
    output logic [WIDTH-1:0] o_resp_data,
    output logic             o_mul_rst,
    output logic             o_mul_load,
    output logic [WIDTH-1:0] o_mul_a,
    output logic [WIDTH-1:0] o_mul_b,
    input  logic [WIDTH-1:0] i_mul_res,
    output logic             o_busy
);

    // One down-counter times both LOAD and RUN, so it is sized for the longer of the two.
    localparam int MAX_CYC = (LOAD_CYCLES > LATENCY) ? LOAD_CYCLES : LATENCY;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] RUN_INIT  = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_prio;       // 0: port 0 preferred on contention, 1: port 1
    logic             r_live;       // holds off grants for the first cycle after reset release
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_data;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic             r_mul_rst;
    logic             r_mul_load;
    logic             r_busy;

    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_sel;

    // Round-robin grant: a lone requester always wins, contention resolved by r_prio; only offered in IDLE.
    always_comb begin
        w_grant = 2'b00;
        if (r_live && (r_state == ST_IDLE)) begin
            case (i_req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_accept = |(w_grant & i_req_valid);
    assign w_sel    = w_grant[1];

    // Operation sequencer: IDLE -> LOAD (LOAD_CYCLES) -> RUN (LATENCY) -> DONE (until consumed).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_prio       <= 1'b0;
            r_live       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_rst    <= 1'b1;
            r_mul_load   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Operands stay registered until the next accept so the multiplier sees stable inputs.
                        r_mul_a    <= w_sel ? i_req_a1 : i_req_a0;
                        r_mul_b    <= w_sel ? i_req_b1 : i_req_b0;
                        r_resp_id  <= w_sel;
                        r_prio     <= ~w_sel;
                        r_cnt      <= LOAD_INIT;
                        r_state    <= ST_LOAD;
                        r_mul_rst  <= 1'b0;
                        r_mul_load <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (r_cnt == '0) begin
                        r_cnt      <= RUN_INIT;
                        r_state    <= ST_RUN;
                        r_mul_load <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == '0) begin
                        // Final RUN edge: the multiplier output is valid now and is frozen for the consumer.
                        r_resp_data  <= i_mul_res;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE re-asserts o_mul_rst for at least one cycle before the next load.
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                        r_mul_rst    <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_mul_rst    <= 1'b1;
                    r_mul_load   <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = w_grant;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_id    = r_resp_id;
    assign o_resp_data  = r_resp_data;
    assign o_mul_rst    = r_mul_rst;
    assign o_mul_load   = r_mul_load;
    assign o_mul_a      = r_mul_a;
    assign o_mul_b      = r_mul_b;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_fmul_sched.sv
// Purpose: directed self-checking bench for fmul_sched with a behavioural FP32 multiplier behind it.
// Latency: expects first o_resp_valid 38 cycles after each request handshake (default parameters).
// Backpressure: holds i_resp_ready low in DONE and checks the response is frozen and requests are refused.
module tb_fmul_sched;

    localparam int WIDTH       = 32;
    localparam int LOAD_CYCLES = 2;
    localparam int LATENCY     = 35;
    localparam int RESP_LAT    = 1 + LOAD_CYCLES + LATENCY;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_ready;
    logic [31:0] i_req_a0, i_req_b0, i_req_a1, i_req_b1;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic        o_resp_id;
    logic [31:0] o_resp_data;
    logic        o_mul_rst;
    logic        o_mul_load;
    logic [31:0] o_mul_a, o_mul_b;
    logic [31:0] i_mul_res;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int run_cnt = 0;
    int load_len = 0;
    logic prev_load = 1'b0;
    logic rst_seen = 1'b1;

    fmul_sched #(
        .WIDTH      (WIDTH),
        .LOAD_CYCLES(LOAD_CYCLES),
        .LATENCY    (LATENCY)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a0    (i_req_a0),
        .i_req_b0    (i_req_b0),
        .i_req_a1    (i_req_a1),
        .i_req_b1    (i_req_b1),
        .o_resp_valid(o_resp_valid),
        .i_resp_ready(i_resp_ready),
        .o_resp_id   (o_resp_id),
        .o_resp_data (o_resp_data),
        .o_mul_rst   (o_mul_rst),
        .o_mul_load  (o_mul_load),
        .o_mul_a     (o_mul_a),
        .o_mul_b     (o_mul_b),
        .i_mul_res   (i_mul_res),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Truncating FP32 multiply, good enough for the normal/inf operands used here.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    // Multiplier model: result only becomes valid in the LATENCY-th cycle after load falls.
    always @(posedge i_clk) begin
        if (o_mul_rst || o_mul_load) run_cnt <= 0;
        else                         run_cnt <= run_cnt + 1;
    end

    always_comb begin
        i_mul_res = 32'hDEADBEEF;
        if (!o_mul_rst && !o_mul_load && run_cnt >= LATENCY - 1) i_mul_res = fp_mul(o_mul_a, o_mul_b);
    end

    // Protocol monitor: handshake timestamps, one-hot ready only in IDLE, load length, reset gap.
    always @(negedge i_clk) begin
        if (o_req_ready != 2'b00) begin
            chk("ready_onehot", 32'($countones(o_req_ready)), 32'd1);
            chk("ready_in_idle", 32'(o_mul_rst), 32'd1);
        end
        if (|(i_req_valid & o_req_ready)) hs_cyc = cyc;
        if (o_mul_load && !prev_load) begin
            chk("rst_gap", 32'(rst_seen), 32'd1);
            rst_seen = 1'b0;
        end
        if (o_mul_rst) rst_seen = 1'b1;
        if (o_mul_load) begin
            load_len++;
        end else if (load_len != 0) begin
            chk("load_len", 32'(load_len), 32'(LOAD_CYCLES));
            load_len = 0;
        end
        prev_load = o_mul_load;
    end

    // Wait for a response, check latency/id/data, optionally stall, then consume it.
    task automatic get_resp(input string tag, input logic exp_id, input logic [31:0] exp_data,
                            input int hold, input logic drop_valid);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_lat"}, 32'(cyc - hs_cyc), 32'(RESP_LAT));
            chk({tag, "_id"}, 32'(o_resp_id), 32'(exp_id));
            chk({tag, "_data"}, o_resp_data, exp_data);
            for (int k = 0; k < hold; k++) begin
                @(negedge i_clk);
                chk({tag, "_hold_vld"}, 32'(o_resp_valid), 32'd1);
                chk({tag, "_hold_data"}, o_resp_data, exp_data);
                chk({tag, "_hold_id"}, 32'(o_resp_id), 32'(exp_id));
                chk({tag, "_hold_rdy"}, 32'(o_req_ready), 32'd0);
            end
            #1;
            if (drop_valid) i_req_valid = 2'b00;
            i_resp_ready = 1'b1;
            @(posedge i_clk);
            #1 i_resp_ready = 1'b0;
        end
    endtask

    // Present a lone request on one port and drop it after its handshake.
    task automatic send_one(input string tag, input int port, input logic [31:0] a, input logic [31:0] b);
        bit acc = 1'b0;
        @(posedge i_clk);
        #1;
        if (port == 0) begin
            i_req_a0 = a;
            i_req_b0 = b;
            i_req_valid = 2'b01;
        end else begin
            i_req_a1 = a;
            i_req_b1 = b;
            i_req_valid = 2'b10;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_req_ready != 2'b00) begin
                acc = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, 32'(o_req_ready), (port == 0) ? 32'd1 : 32'd2);
        @(posedge i_clk);
        #1 i_req_valid = 2'b00;
        if (acc) begin
            @(negedge i_clk);
            chk({tag, "_load"}, 32'({o_mul_load, o_mul_rst, o_busy}), 32'b101);
            chk({tag, "_mul_a"}, o_mul_a, a);
            chk({tag, "_mul_b"}, o_mul_b, b);
        end
    endtask

    initial begin
        bit seen;
        i_rst_n      = 1'b0;
        i_resp_ready = 1'b0;
        i_req_valid  = 2'b11;
        i_req_a0     = 32'h40600000;
        i_req_b0     = 32'h425D0000;
        i_req_a1     = 32'hC0000000;
        i_req_b1     = 32'h3E000000;

        // Reset state, with both requesters already valid.
        repeat (2) @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_mul_rst", 32'(o_mul_rst), 32'd1);
        chk("rst_mul_load", 32'(o_mul_load), 32'd0);
        chk("rst_resp_vld", 32'(o_resp_valid), 32'd0);
        chk("rst_req_rdy", 32'(o_req_ready), 32'd0);
        chk("rst_resp_id", 32'(o_resp_id), 32'd0);
        chk("rst_resp_data", o_resp_data, 32'd0);
        chk("rst_mul_a", o_mul_a, 32'd0);
        chk("rst_mul_b", o_mul_b, 32'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Contention from reset then fairness: port 0 first, strict alternation over 6 ops.
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) get_resp("rr_p0", 1'b0, 32'h43416000, 0, n == 5);
            else            get_resp("rr_p1", 1'b1, 32'hBE800000, 0, n == 5);
        end
        @(negedge i_clk);
        chk("rr_idle_after", 32'({o_busy, o_resp_valid}), 32'd0);

        // Lone requester on port 1 (priority sits on port 0) with a 10-cycle stall; inf passes through.
        send_one("bp", 1, 32'h7F800000, 32'h40000000);
        get_resp("bp", 1'b1, 32'h7F800000, 10, 1'b0);
        @(negedge i_clk);
        chk("bp_single_resp", 32'(o_resp_valid), 32'd0);

        // Single op on port 0.
        send_one("single", 0, 32'hC0000000, 32'h3E000000);
        get_resp("single", 1'b0, 32'hBE800000, 0, 1'b0);

        // Reset in the middle of RUN aborts the operation.
        send_one("abort", 0, 32'h40600000, 32'h425D0000);
        while (cyc < hs_cyc + 20) @(negedge i_clk);
        chk("abort_busy_pre", 32'(o_busy), 32'd1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_mul_rst", 32'(o_mul_rst), 32'd1);
        chk("abort_resp_vld", 32'(o_resp_valid), 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge i_clk);
            if (o_resp_valid) seen = 1'b1;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        send_one("post", 0, 32'h40600000, 32'h425D0000);
        get_resp("post", 1'b0, 32'h43416000, 0, 1'b0);

        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fmul_sched.md
FMUL_SCHED -- requirements
Module: fmul_sched

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand/result width (IEEE-754 single).
REQ-002 Parameter LOAD_CYCLES, default 2, SHALL set the number of cycles o_mul_load is held high per operation (>=1).
REQ-003 Parameter LATENCY, default 35, SHALL set the number of cycles from load deassertion until i_mul_res is sampled (>=1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be (name  direction  width  meaning):
 i_clk  in  1  clock, rising edge
 i_rst_n  in  1  async active-low reset
 i_req_valid  in  2  per-requester request valid
 o_req_ready  out  2  per-requester accept; one-hot or zero
 i_req_a0, i_req_b0  in  WIDTH  requester 0 operands
 i_req_a1, i_req_b1  in  WIDTH  requester 1 operands
 o_resp_valid  out  1  result available
 i_resp_ready  in  1  consumer accepts result
 o_resp_id  out  1  requester index owning the result
 o_resp_data  out  WIDTH  product
 o_mul_rst  out  1  multiplier reset, active-high
 o_mul_load  out  1  multiplier load strobe
 o_mul_a, o_mul_b  out  WIDTH  multiplier operands
 i_mul_res  in  WIDTH  multiplier result
 o_busy  out  1  high in any state except IDLE

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-007 In IDLE, o_mul_rst SHALL be 1 and o_mul_load 0; in LOAD, o_mul_rst 0 and o_mul_load 1; in RUN and DONE, both 0.
REQ-008 o_req_ready SHALL be nonzero only in IDLE and SHALL be asserted only to the arbitration winner among asserted i_req_valid bits.
REQ-009 Arbitration SHALL be round-robin: a priority bit selects the preferred port; a lone requester always wins; after a grant to port k, priority moves to port 1-k.
REQ-010 On a handshake (valid & ready) the block SHALL register that port's operands into o_mul_a/o_mul_b, register the port index into o_resp_id, and enter LOAD.
REQ-011 o_mul_a/o_mul_b SHALL hold stable from LOAD entry until the next accept.
REQ-012 LOAD SHALL last exactly LOAD_CYCLES cycles, then enter RUN; a down-counter of width clog2(max(LOAD_CYCLES,LATENCY))+1 SHALL time both LOAD and RUN.
REQ-013 RUN SHALL last exactly LATENCY cycles; on the final RUN edge i_mul_res SHALL be captured into o_resp_data and the FSM enters DONE.
REQ-014 With a handshake in cycle T, o_resp_valid SHALL first be high in cycle T+1+LOAD_CYCLES+LATENCY (T+38 with defaults).
REQ-015 In DONE, o_resp_valid SHALL be 1 with o_resp_data/o_resp_id stable until i_resp_ready is sampled high; then the FSM returns to IDLE.
REQ-016 No request SHALL be accepted in the cycle of the response handshake; the earliest next accept is the following IDLE cycle, guaranteeing >=1 cycle of o_mul_rst between operations.
REQ-017 i_req_valid changes during LOAD/RUN/DONE SHALL have no effect; requesters hold valid until ready.
REQ-018 The block SHALL NOT interpret data; NaN/Inf/subnormal results pass through unmodified.

Reset
REQ-019 On i_rst_n low, asynchronously: state IDLE, counter 0, priority to port 0, o_resp_valid 0, o_resp_id 0, o_resp_data 0, o_mul_a/o_mul_b 0, o_mul_load 0, o_mul_rst 1, o_req_ready 0, o_busy 0.
REQ-020 Reset asserted in any state SHALL abort the operation without emitting a response; after release the FSM starts from IDLE.

Verification
REQ-021 Single op: port 0 A=0xC0000000 (-2.0), B=0x3E000000 (0.125), behavioural multiplier model -> o_resp_valid at T+38, o_resp_data=0xBE800000, o_resp_id=0.
REQ-022 Contention: both ports valid from reset, port 0 A=0x40600000 x 0x425D0000, port 1 A=0xC0000000 x 0x3E000000 -> first response id 0 data 0x43416000, second id 1 data 0xBE800000.
REQ-023 Fairness: both ports continuously valid for 6 operations -> o_resp_id sequence 0,1,0,1,0,1.
REQ-024 Backpressure: hold i_resp_ready=0 for 10 cycles in DONE -> o_resp_valid/data/id stable, o_req_ready=0 throughout, one response delivered on release.
REQ-025 Reset mid-RUN: drop i_rst_n at cycle T+20 -> immediately o_busy=0, o_mul_rst=1, o_resp_valid=0; no response; new request after release completes at T'+38.
REQ-026 Protocol check: o_mul_load high exactly LOAD_CYCLES consecutive cycles per op, o_mul_rst high >=1 cycle between ops, o_req_ready never multi-hot.
